// File: rtl/ascon_state_loader.sv
`default_nettype none
// ============================================================================
// Module      : ascon_state_loader
// Description : Loads IV/key/nonce bit-serially into the one-round Ascon
//               permutation and streams the per-round constant. The abort
//               input exists only when ASCON_LOADER_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_state_loader #(
    parameter int ROUNDS       = 6,
    parameter int ROUND_PERIOD = 448,
    parameter int CONST_OFS    = 56
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  iv,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
`ifdef ASCON_LOADER_ABORT_EN
    input  logic         abort,
`endif
    output logic [4:0]   input_data,
    output logic         constant,
    output logic         start_permutation,
    output logic [3:0]   iteration,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = $clog2(ROUND_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tcnt;
    logic [3:0]         rcnt;
    logic [63:0]        iv_sr;
    logic [63:0]        key_hi_sr;
    logic [63:0]        key_lo_sr;
    logic [63:0]        nonce_hi_sr;
    logic [63:0]        nonce_lo_sr;

    logic               t_wrap;
    logic [CNT_W-1:0]   t_nxt;
    logic [3:0]         r_nxt;
    logic               last_cycle;
    logic               load_last;
    logic               abort_hit;

    assign t_wrap     = (tcnt == CNT_W'(ROUND_PERIOD - 1));
    assign t_nxt      = t_wrap ? '0 : tcnt + 1'b1;
    assign r_nxt      = t_wrap ? rcnt + 4'd1 : rcnt;
    assign last_cycle = t_wrap && (rcnt == 4'(ROUNDS - 1));
    assign load_last  = (rcnt == 4'd0) && (tcnt == CNT_W'(63));
    assign iteration  = 4'(ROUNDS);

`ifdef ASCON_LOADER_ABORT_EN
    assign abort_hit = abort && (state == S_LOAD || state == S_RUN);
`else
    assign abort_hit = 1'b0;
`endif

    // Round constant i is {15-i, i}, which reproduces f0 e1 d2 ... 4b.
    function automatic logic const_bit(input logic [3:0] rnd, input logic [CNT_W-1:0] tt);
        int unsigned ti;
        int unsigned ci;
        int unsigned b;
        logic [7:0]  cr;
        ti = 32'(tt);
        ci = 32'(12 - ROUNDS) + 32'(rnd);
        cr = {4'(15 - ci), 4'(ci)};
        if (ti >= CONST_OFS && ti < CONST_OFS + 8) begin
            b = CONST_OFS + 7 - ti;
            return cr[b[2:0]];
        end
        return 1'b0;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            tcnt              <= '0;
            rcnt              <= '0;
            iv_sr             <= '0;
            key_hi_sr         <= '0;
            key_lo_sr         <= '0;
            nonce_hi_sr       <= '0;
            nonce_lo_sr       <= '0;
            input_data        <= '0;
            constant          <= 1'b0;
            start_permutation <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            in_ready          <= 1'b1;
        end else if (abort_hit) begin
            state             <= S_IDLE;
            tcnt              <= '0;
            rcnt              <= '0;
            iv_sr             <= '0;
            key_hi_sr         <= '0;
            key_lo_sr         <= '0;
            nonce_hi_sr       <= '0;
            nonce_lo_sr       <= '0;
            input_data        <= '0;
            constant          <= 1'b0;
            start_permutation <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            in_ready          <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        // Bit 63 goes straight out; the shifters hold the remainder.
                        state             <= S_LOAD;
                        tcnt              <= '0;
                        rcnt              <= '0;
                        input_data        <= {iv[63], key[127], key[63], nonce[127], nonce[63]};
                        iv_sr             <= {iv[62:0], 1'b0};
                        key_hi_sr         <= {key[126:64], 1'b0};
                        key_lo_sr         <= {key[62:0], 1'b0};
                        nonce_hi_sr       <= {nonce[126:64], 1'b0};
                        nonce_lo_sr       <= {nonce[62:0], 1'b0};
                        constant          <= const_bit(4'd0, '0);
                        start_permutation <= 1'b1;
                        busy              <= 1'b1;
                        in_ready          <= 1'b0;
                    end
                end
                S_LOAD, S_RUN: begin
                    tcnt <= t_nxt;
                    rcnt <= r_nxt;
                    if (state == S_LOAD && !load_last) begin
                        input_data  <= {iv_sr[63], key_hi_sr[63], key_lo_sr[63],
                                        nonce_hi_sr[63], nonce_lo_sr[63]};
                        iv_sr       <= {iv_sr[62:0], 1'b0};
                        key_hi_sr   <= {key_hi_sr[62:0], 1'b0};
                        key_lo_sr   <= {key_lo_sr[62:0], 1'b0};
                        nonce_hi_sr <= {nonce_hi_sr[62:0], 1'b0};
                        nonce_lo_sr <= {nonce_lo_sr[62:0], 1'b0};
                    end else begin
                        input_data  <= '0;
                    end
                    if (last_cycle) begin
                        state             <= S_DONE;
                        constant          <= 1'b0;
                        start_permutation <= 1'b0;
                        busy              <= 1'b0;
                        done              <= 1'b1;
                    end else begin
                        constant <= const_bit(r_nxt, t_nxt);
                        if (state == S_LOAD && load_last) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
